// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams instruction words into IMEM, then runs the CPU for a fixed cycle budget
module imem_boot_loader #(
    parameter int IMEM_DEPTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] word_count_i,
    input  logic [CNT_W-1:0] run_cycles_i,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    output logic             in_ready_o,
    output logic             imem_we_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_wdata_o,
    output logic             cpu_rst_n_o,
    output logic             cpu_run_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             imem_we_q, imem_we_d;
    logic [31:0]      imem_addr_q, imem_addr_d;
    logic [31:0]      imem_wdata_q, imem_wdata_d;
    logic             cpu_rst_n_q, cpu_rst_n_d;
    logic             cpu_run_q, cpu_run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             count_ok;

    assign count_ok = (word_count_i != '0) && (word_count_i <= CNT_W'(IMEM_DEPTH));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        in_ready_d   = in_ready_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_rst_n_d  = cpu_rst_n_q;
        cpu_run_d    = cpu_run_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    if (!count_ok) begin
                        err_d = 1'b1;
                    end else begin
                        wcnt_d      = word_count_i;
                        rcnt_d      = run_cycles_i;
                        idx_d       = '0;
                        cycle_cnt_d = '0;
                        done_d      = 1'b0;
                        busy_d      = 1'b1;
                        in_ready_d  = 1'b1;
                        cpu_rst_n_d = 1'b0;
                        state_d     = LOAD;
                    end
                end
            end
            LOAD: begin
                if (in_valid_i && in_ready_q) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = 32'(idx_q) << 2;
                    imem_wdata_d = in_data_i;
                    idx_d        = idx_q + CNT_W'(1);
                    if (idx_q + CNT_W'(1) == wcnt_q) begin
                        in_ready_d = 1'b0;
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // CPU leaves reset here whether or not it will execute any cycles
                cpu_rst_n_d = 1'b1;
                if (rcnt_q == '0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    cpu_run_d = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (cpu_run_q) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                    if (cycle_cnt_q + CNT_W'(1) == rcnt_q) begin
                        cpu_run_d = 1'b0;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            wcnt_q       <= '0;
            rcnt_q       <= '0;
            cycle_cnt_q  <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_rst_n_q  <= 1'b0;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wcnt_q       <= wcnt_d;
            rcnt_q       <= rcnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            cpu_run_q    <= cpu_run_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign imem_we_o    = imem_we_q;
    assign imem_addr_o  = imem_addr_q;
    assign imem_wdata_o = imem_wdata_q;
    assign cpu_rst_n_o  = cpu_rst_n_q;
    assign cpu_run_o    = cpu_run_q;
    assign cycle_cnt_o  = cycle_cnt_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for Simple_Single_CPU, replacing simulation-only instruction preloading.
- Holds the CPU in reset and accepts a stream of 32-bit instruction words over a valid/ready interface. Writes each word into the instruction memory write port at consecutive word addresses.
- Then releases the CPU for a programmed number of cycles, freezes it, and flags completion so the register file can be read out.

Parameters:
- IMEM_DEPTH, 32, instruction memory size in words; maximum legal word count.
- CNT_W, 16, width of word-count, run-cycle and cycle-counter fields.

Ports:
- clk_i, input, 1, system clock; all logic on rising edge.
- rst_i, input, 1, synchronous active-high reset.
- start_i, input, 1, begin a load/run session; sampled in IDLE and DONE only.
- word_count_i, input, CNT_W, number of words to load; latched on accepted start.
- run_cycles_i, input, CNT_W, CPU run length in cycles; latched on accepted start.
- in_valid_i, input, 1, instruction word valid.
- in_data_i, input, 32, instruction word.
- in_ready_o, output, 1, loader accepts a word this cycle.
- imem_we_o, output, 1, instruction memory write strobe.
- imem_addr_o, output, 32, byte address of write (word index * 4).
- imem_wdata_o, output, 32, write data.
- cpu_rst_n_o, output, 1, active-low reset to CPU; 0 holds CPU in reset.
- cpu_run_o, output, 1, CPU enable; qualifies PC update and all architectural writes.
- cycle_cnt_o, output, CNT_W, CPU cycles executed this session.
- busy_o, output, 1, session in progress (LOAD/FLUSH/RUN).
- done_o, output, 1, session complete.
- err_o, output, 1, one-cycle pulse on rejected start.

Behaviour:
- All outputs are registered.
- Reset: state IDLE; every output 0; internal word index 0.
- States: IDLE, LOAD, FLUSH, RUN, DONE.
- IDLE/DONE with start_i=1:
  - word_count_i==0 or >IMEM_DEPTH: err_o=1 for exactly one cycle; state unchanged; done_o unchanged.
  - Otherwise: latch counts, clear index and cycle_cnt_o, clear done_o, go LOAD.
  - In LOAD: in_ready_o=1 and busy_o=1 from the next cycle.
- start_i is ignored in LOAD/FLUSH/RUN.
- LOAD:
  - in_ready_o=1 throughout, including the cycle of the final handshake.
  - Handshake = in_valid_i & in_ready_o at a rising edge. On the next cycle: imem_we_o=1, imem_addr_o=index*4, imem_wdata_o=data; index increments.
  - imem_we_o=0 in cycles after no handshake; addr/wdata hold their last value.
  - in_valid_i without in_ready_o is ignored; no data is captured.
  - Final handshake (index==count-1) at edge t: state FLUSH, in_ready_o=0 from t+1, last write visible at t+1.
- FLUSH: lasts one cycle, cpu_rst_n_o=0. Next state is RUN, or DONE if the latched run_cycles==0.
- RUN:
  - cpu_rst_n_o=1, cpu_run_o=1.
  - cycle_cnt_o increments on each edge while cpu_run_o=1.
  - Leaves RUN after exactly run_cycles edges with cpu_run_o=1; cpu_run_o=0 on the following cycle.
- DONE:
  - done_o=1, busy_o=0, cpu_run_o=0, cpu_rst_n_o stays 1 (CPU state preserved for readout).
  - cycle_cnt_o holds the final value.
  - Accepted restart drops cpu_rst_n_o to 0 on entering LOAD.
- cpu_rst_n_o=0 in IDLE, LOAD and FLUSH; 1 in RUN and DONE.
- rst_i mid-session: all outputs return to reset values on that edge; partial load is abandoned; CPU is held in reset.
- Index and counters use CNT_W bits. cycle_cnt_o never exceeds run_cycles, so no wrap occurs.

Test Plan:
- Load: start, word_count=3, run=5, words 0x20010003/0x20020004/0x00221820 with continuous valid.
  - Writes at addrs 0, 4, 8 with matching data, one per cycle.
  - cpu_rst_n_o rises 2 cycles after the last handshake.
  - cpu_run_o high exactly 5 cycles; then done_o=1, cycle_cnt_o=5.
- Backpressure gaps: in_valid_i toggling 1,0,0,1,0,1 with count=3.
  - Exactly 3 writes, each one cycle after its handshake, at addrs 0, 4, 8.
  - No writes in idle cycles; in_ready_o drops after the 3rd.
- Bad counts: start with word_count=0, then word_count=33.
  - Each gives a single-cycle err_o pulse; state stays IDLE; in_ready_o=0; cpu_rst_n_o=0.
- Zero run: word_count=1, run=0.
  - cpu_run_o never asserts; done_o=1 one cycle after FLUSH; cycle_cnt_o=0.
- Reset mid-LOAD after 2 handshakes (count=4).
  - All outputs are 0 next cycle.
  - A fresh start with count=2 writes from addr 0 again and completes normally.
- Restart from DONE with count=1, run=2.
  - done_o clears, cpu_rst_n_o=0 in LOAD, cycle_cnt_o restarts from 0 and ends at 2.
